// File: rtl/iommu_wsi_irq_gen.sv
// iommu_wsi_irq_gen: maps IOMMU interrupt causes onto PLIC wires in level or pulse mode
module iommu_wsi_irq_gen #(
    parameter int NumCauses   = 4,
    parameter int NumWires    = 4,
    parameter int VecWidth    = 4,
    parameter int PulseCycles = 8,
    parameter int GapCycles   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wsi_en_i,
    input  logic                          pulse_mode_i,
    input  logic [NumCauses-1:0]          cause_pend_i,
    input  logic [NumCauses-1:0]          cause_ie_i,
    input  logic [NumCauses*VecWidth-1:0] cause_vec_i,
    output logic [NumWires-1:0]           wire_o,
    output logic                          busy_o
);
    localparam int MaxCyc = PulseCycles > GapCycles ? PulseCycles : GapCycles;
    localparam int CW = $clog2(MaxCyc + 1);
    localparam logic [VecWidth-1:0] Mask = VecWidth'(NumWires - 1);
    localparam logic [CW-1:0] PLoad = CW'(PulseCycles - 1);
    localparam logic [CW-1:0] GLoad = CW'(GapCycles - 1);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    logic [NumCauses-1:0] act, hist_q, rise;
    logic [NumWires-1:0]  req, trig, rt_q, rt_n, pulse_n, busy_n;
    state_t               st_q [NumWires];
    state_t               st_n [NumWires];
    logic [CW-1:0]        cnt_q [NumWires];
    logic [CW-1:0]        cnt_n [NumWires];
    logic                 mode_q, clr;
    assign act  = cause_pend_i & cause_ie_i;
    assign rise = act & ~hist_q;
    assign clr  = ~wsi_en_i | (pulse_mode_i != mode_q);
    // route each cause's level and rising edge to the wire selected by its vector modulo NumWires
    always_comb begin
        req  = '0;
        trig = '0;
        for (int c = 0; c < NumCauses; c++)
            for (int w = 0; w < NumWires; w++)
                if ((cause_vec_i[c*VecWidth +: VecWidth] & Mask) == VecWidth'(w)) begin
                    req[w]  = req[w] | act[c];
                    trig[w] = trig[w] | rise[c];
                end
    end
    // per-wire pulse FSM next state; disable, mode switch and level mode hold every FSM idle
    always_comb begin
        rt_n = rt_q;
        for (int w = 0; w < NumWires; w++) begin
            st_n[w]  = st_q[w];
            cnt_n[w] = cnt_q[w];
            if (clr || !pulse_mode_i) begin
                st_n[w]  = IDLE;
                cnt_n[w] = '0;
                rt_n[w]  = 1'b0;
            end else if (st_q[w] == IDLE) begin
                st_n[w]  = trig[w] ? PULSE : IDLE;
                cnt_n[w] = trig[w] ? PLoad : cnt_q[w];
            end else begin
                rt_n[w] = rt_q[w] | trig[w];
                if (cnt_q[w] != '0) begin
                    cnt_n[w] = cnt_q[w] - CW'(1);
                end else if (st_q[w] == PULSE) begin
                    st_n[w]  = GAP;
                    cnt_n[w] = GLoad;
                end else if (rt_q[w] || trig[w]) begin
                    st_n[w]  = PULSE;
                    cnt_n[w] = PLoad;
                    rt_n[w]  = 1'b0;
                end else begin
                    st_n[w] = IDLE;
                end
            end
            pulse_n[w] = st_n[w] == PULSE;
            busy_n[w]  = st_n[w] != IDLE;
        end
    end
    // register FSM state, edge history, mode and the wire outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= 1'b0;
            hist_q <= '0;
            rt_q   <= '0;
            wire_o <= '0;
            busy_o <= 1'b0;
            for (int w = 0; w < NumWires; w++) begin
                st_q[w]  <= IDLE;
                cnt_q[w] <= '0;
            end
        end else begin
            mode_q <= pulse_mode_i;
            hist_q <= clr ? '0 : act;
            rt_q   <= rt_n;
            wire_o <= clr ? '0 : pulse_mode_i ? pulse_n : req;
            busy_o <= |busy_n;
            for (int w = 0; w < NumWires; w++) begin
                st_q[w]  <= st_n[w];
                cnt_q[w] <= cnt_n[w];
            end
        end
    end
endmodule

// File: tb/tb_iommu_wsi_irq_gen.sv
// tb_iommu_wsi_irq_gen: directed per-cycle expectations checked by a queue-driven monitor
module tb_iommu_wsi_irq_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pm = 1'b0;
    logic [3:0]  pend = '0;
    logic [3:0]  ie = 4'hf;
    logic [15:0] vec = {4'd3, 4'd2, 4'd5, 4'd1};
    logic [3:0]  wire_o;
    logic        busy_o;
    int          compared = 0;
    int          mismatched = 0;
    typedef struct {
        logic [3:0] w;
        logic       b;
        string      tag;
    } exp_t;
    exp_t q[$];

    iommu_wsi_irq_gen dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wsi_en_i    (en),
        .pulse_mode_i(pm),
        .cause_pend_i(pend),
        .cause_ie_i  (ie),
        .cause_vec_i (vec),
        .wire_o      (wire_o),
        .busy_o      (busy_o)
    );

    initial forever #5 clk = ~clk;

    task automatic step(input logic [3:0] ew, input logic eb, input string tag);
        exp_t e;
        e.w = ew;
        e.b = eb;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [3:0] ew, input logic eb, input string tag);
        for (int i = 0; i < n; i++) step(ew, eb, tag);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if (wire_o !== e.w || busy_o !== e.b) begin
                    mismatched++;
                    $display("FAIL %s @%0t: wire_o=%b busy_o=%b, expected wire_o=%b busy_o=%b",
                             e.tag, $time, wire_o, busy_o, e.w, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        mismatched++;
        $display("FAIL watchdog: stimulus did not complete, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        hold(2, 4'h0, 1'b0, "reset");
        rst = 1'b0;
        hold(2, 4'h0, 1'b0, "idle");
        pend = 4'b0001;
        hold(2, 4'b0010, 1'b0, "lvl_cq");
        pend = 4'b0011;
        hold(2, 4'b0010, 1'b0, "lvl_cq_fq");
        pend = 4'b0010;
        hold(2, 4'b0010, 1'b0, "lvl_fq");
        pend = 4'b0000;
        hold(2, 4'b0000, 1'b0, "lvl_drop");
        ie = 4'b1110;
        pend = 4'b0001;
        step(4'b0000, 1'b0, "lvl_ie_mask");
        ie = 4'hf;
        pend = 4'b0100;
        step(4'b0100, 1'b0, "lvl_hpm");
        pend = 4'b1100;
        step(4'b1100, 1'b0, "lvl_two_wires");
        pend = 4'b1000;
        step(4'b1000, 1'b0, "lvl_pq");
        pm = 1'b1;
        step(4'b0000, 1'b0, "switch_low");
        hold(8, 4'b1000, 1'b1, "pulse_width");
        hold(2, 4'b0000, 1'b1, "pulse_gap");
        hold(4, 4'b0000, 1'b0, "held_no_refire");
        pend = 4'b0000;
        vec = {4'd3, 4'd2, 4'd5, 4'd2};
        hold(2, 4'b0000, 1'b0, "quiet");
        pend = 4'b0100;
        hold(3, 4'b0100, 1'b1, "retrig_p1");
        pend = 4'b0101;
        hold(5, 4'b0100, 1'b1, "retrig_p1");
        hold(2, 4'b0000, 1'b1, "retrig_gap1");
        hold(8, 4'b0100, 1'b1, "retrig_p2");
        hold(2, 4'b0000, 1'b1, "retrig_gap2");
        hold(3, 4'b0000, 1'b0, "retrig_no_third");
        pend = 4'b0000;
        vec = {4'd3, 4'd2, 4'd0, 4'd0};
        step(4'b0000, 1'b0, "quiet");
        pend = 4'b0011;
        hold(8, 4'b0001, 1'b1, "simul_pulse");
        hold(2, 4'b0000, 1'b1, "simul_gap");
        hold(2, 4'b0000, 1'b0, "simul_idle");
        pend = 4'b0000;
        vec = {4'd3, 4'd2, 4'd5, 4'd1};
        step(4'b0000, 1'b0, "quiet");
        pend = 4'b0010;
        hold(3, 4'b0010, 1'b1, "dis_pulse");
        en = 1'b0;
        hold(2, 4'b0000, 1'b0, "disabled");
        en = 1'b1;
        hold(8, 4'b0010, 1'b1, "reen_pulse");
        hold(2, 4'b0000, 1'b1, "reen_gap");
        hold(2, 4'b0000, 1'b0, "reen_idle");
        pend = 4'b0000;
        step(4'b0000, 1'b0, "quiet");
        pend = 4'b0001;
        hold(8, 4'b0010, 1'b1, "vec_pulse");
        hold(2, 4'b0000, 1'b1, "vec_gap");
        vec = {4'd3, 4'd2, 4'd5, 4'd3};
        hold(3, 4'b0000, 1'b0, "vec_change_no_edge");
        pend = 4'b0000;
        step(4'b0000, 1'b0, "quiet");
        pend = 4'b1000;
        hold(3, 4'b1000, 1'b1, "rst_pulse");
        rst = 1'b1;
        step(4'b0000, 1'b0, "rst_mid_pulse");
        rst = 1'b0;
        pend = 4'b0000;
        hold(2, 4'b0000, 1'b0, "post_rst");
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
